// File: rtl/traffic_pkg.sv
// traffic_pkg: controller state encoding and round-robin phase search
package traffic_pkg;
    typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW, FLASH} state_e;
    function automatic int rr_next(input logic [7:0] req, input int cur, input int n);
        int idx;
        logic found;
        rr_next = cur;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = (cur + k) % n;
            if (k <= n && !found && req[3'(idx)]) begin
                rr_next = idx;
                found = 1'b1;
            end
        end
    endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating tick counter with synchronous clear
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;
    always_comb count_d = clr_i ? '0 : (tick_i && ~&count_q) ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
    assign count_o = count_q;
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase intersection controller with request latching, extension, recall and flash
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_PHASES      = 4,
    parameter int CNT_W         = 8,
    parameter int GREEN_MIN     = 5,
    parameter int GREEN_MAX     = 10,
    parameter int YELLOW_T      = 2,
    parameter int ALLRED_T      = 1,
    parameter int DEFAULT_PHASE = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick_i,
    input  logic [N_PHASES-1:0]         sensor_i,
    input  logic                        maint_flash_i,
    output logic [N_PHASES-1:0]         green_o,
    output logic [N_PHASES-1:0]         yellow_o,
    output logic [N_PHASES-1:0]         red_o,
    output logic [$clog2(N_PHASES)-1:0] active_phase_o,
    output logic [N_PHASES-1:0]         pending_o,
    output logic                        flash_o
);
    localparam int AW = $clog2(N_PHASES);
    localparam logic [N_PHASES-1:0] ONE = {{(N_PHASES-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] DEF = AW'(DEFAULT_PHASE);
    localparam logic [CNT_W-1:0] T_AR = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] T_Y = CNT_W'(YELLOW_T);
    state_e state_q, state_d;
    logic [AW-1:0] act_q, act_d, nxt_q, nxt_d;
    logic [N_PHASES-1:0] pend_q, pend_d, act_oh, other, req, clr;
    logic fph_q, fph_d, recall;
    logic [CNT_W-1:0] count;
    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .tick_i (tick_i),
        .clr_i  (state_d != state_q),
        .count_o(count)
    );
    assign act_oh = ONE << act_q;
    always_comb begin
        other = pend_q & ~act_oh;
        recall = act_q != DEF && other == '0 && !sensor_i[act_q];
        req = recall ? other | (ONE << DEF) : other;
        state_d = state_q;
        act_d = act_q;
        nxt_d = nxt_q;
        clr = '0;
        fph_d = (state_q == FLASH && tick_i) ? ~fph_q : fph_q;
        if (maint_flash_i) state_d = FLASH;
        else unique case (state_q)
            ALL_RED: if (count >= T_AR) begin
                state_d = GREEN;
                act_d = nxt_q;
                clr = ONE << nxt_q;
            end
            GREEN: if (count >= T_GMIN && req != '0 && (!sensor_i[act_q] || count >= T_GMAX)) begin
                state_d = YELLOW;
                nxt_d = AW'(rr_next(8'(req), int'(act_q), N_PHASES));
            end
            YELLOW: if (count >= T_Y) state_d = ALL_RED;
            FLASH: begin
                state_d = ALL_RED;
                nxt_d = DEF;
            end
        endcase
        pend_d = (pend_q | (sensor_i & ~(state_q == GREEN ? act_oh : '0))) & ~clr;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ALL_RED;
            act_q <= DEF;
            nxt_q <= DEF;
            pend_q <= '0;
            fph_q <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q <= act_d;
            nxt_q <= nxt_d;
            pend_q <= pend_d;
            fph_q <= fph_d;
        end
    end
    assign green_o = state_q == GREEN ? act_oh : '0;
    assign yellow_o = state_q == YELLOW ? act_oh : '0;
    assign red_o = state_q == FLASH ? {N_PHASES{fph_q}} : ~(green_o | yellow_o);
    assign active_phase_o = act_q;
    assign pending_o = pend_q;
    assign flash_o = state_q == FLASH;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: scoreboard bench for the 4-phase controller
module tb_traffic_phase_ctrl;
    localparam int AR = 0, GR = 1, YE = 2, FL = 3;
    logic clk = 1'b0;
    logic reset, tick_i, maint_flash_i, flash_o;
    logic [3:0] sensor_i, green_o, yellow_o, red_o, pending_o;
    logic [1:0] active_phase_o;
    int checks = 0, errors = 0;
    logic [26:0] sb_q[$];
    int m_st, m_cnt, m_act, m_nxt;
    logic [3:0] m_pend;
    logic m_fph;
    always #5 clk = ~clk;
    traffic_phase_ctrl #(
        .N_PHASES(4), .CNT_W(8), .GREEN_MIN(5), .GREEN_MAX(10),
        .YELLOW_T(2), .ALLRED_T(1), .DEFAULT_PHASE(0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_i        (tick_i),
        .sensor_i      (sensor_i),
        .maint_flash_i (maint_flash_i),
        .green_o       (green_o),
        .yellow_o      (yellow_o),
        .red_o         (red_o),
        .active_phase_o(active_phase_o),
        .pending_o     (pending_o),
        .flash_o       (flash_o)
    );
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask
    function automatic logic [26:0] m_out();
        logic [3:0] g, y, r;
        g = m_st == GR ? 4'(1 << m_act) : 4'b0;
        y = m_st == YE ? 4'(1 << m_act) : 4'b0;
        r = m_st == FL ? {4{m_fph}} : ~(g | y);
        return {g, y, r, 2'(m_act), m_pend, m_st == FL, 8'(m_cnt)};
    endfunction
    task automatic cyc(input logic [3:0] s, input logic m, input logic t, input logic r);
        int ns, na, nn;
        logic [3:0] oth, clr, set;
        sensor_i = s;
        maint_flash_i = m;
        tick_i = t;
        reset = r;
        @(posedge clk);
        if (r) begin
            m_st = AR; m_cnt = 0; m_act = 0; m_nxt = 0; m_pend = 0; m_fph = 0;
        end else begin
            ns = m_st; na = m_act; nn = m_nxt; clr = 0;
            set = s & ~((m_st == GR) ? 4'(1 << m_act) : 4'b0);
            oth = m_pend & ~4'(1 << m_act);
            if (m_act != 0 && oth == 0 && !s[m_act]) oth = 4'b0001;
            if (m) ns = FL;
            else if (m_st == AR) begin
                if (m_cnt >= 1) begin ns = GR; na = m_nxt; clr = 4'(1 << m_nxt); end
            end else if (m_st == GR) begin
                if (m_cnt >= 5 && oth != 0 && (!s[m_act] || m_cnt >= 10)) begin
                    ns = YE;
                    for (int k = 3; k >= 1; k--) if (oth[(m_act + k) % 4]) nn = (m_act + k) % 4;
                end
            end else if (m_st == YE) begin
                if (m_cnt >= 2) ns = AR;
            end else begin
                ns = AR; nn = 0;
            end
            if (m_st == FL && t) m_fph = !m_fph;
            m_cnt = (ns != m_st) ? 0 : (t && m_cnt < 255) ? m_cnt + 1 : m_cnt;
            m_pend = (m_pend | set) & ~clr;
            m_st = ns; m_act = na; m_nxt = nn;
        end
        sb_q.push_back(m_out());
        @(negedge clk);
    endtask
    initial forever begin
        @(negedge clk);
        if (sb_q.size() != 0) begin
            chk("out", {green_o, yellow_o, red_o, active_phase_o, pending_o, flash_o, dut.count}, sb_q.pop_front());
            if (!flash_o) chk("one_lit", 32'($countones(~red_o) <= 1), 1);
        end
    end
    initial begin
        reset = 1; sensor_i = 0; maint_flash_i = 0; tick_i = 1;
        @(negedge clk);
        repeat (3) cyc(0, 0, 1, 1);
        chk("rst_red", red_o, 4'hf);
        chk("rst_green", green_o, 0);
        chk("rst_flash", flash_o, 0);
        chk("rst_pend", pending_o, 0);
        cyc(0, 0, 1, 0);
        chk("rel1_green", green_o, 0);
        cyc(0, 0, 1, 0);
        chk("rel2_green", green_o, 4'b0001);
        repeat (30) cyc(0, 0, 1, 0);
        chk("rest_green", green_o, 4'b0001);
        repeat (260) cyc(0, 0, 1, 0);
        chk("cnt_sat", dut.count, 8'hff);
        cyc(0, 0, 1, 1);
        repeat (2) cyc(0, 0, 1, 0);
        cyc(4'b0100, 0, 1, 0);
        chk("pend_p2", pending_o, 4'b0100);
        repeat (5) cyc(0, 0, 1, 0);
        chk("yel_p0", yellow_o, 4'b0001);
        repeat (3) cyc(0, 0, 1, 0);
        chk("allred", red_o, 4'hf);
        repeat (2) cyc(0, 0, 1, 0);
        chk("green_p2", green_o, 4'b0100);
        chk("pend_clr", pending_o, 0);
        cyc(4'b0101, 0, 1, 0);
        repeat (9) cyc(4'b0100, 0, 1, 0);
        chk("ext_green", green_o, 4'b0100);
        cyc(4'b0100, 0, 1, 0);
        chk("max_yel", yellow_o, 4'b0100);
        repeat (5) cyc(0, 0, 1, 0);
        chk("back_p0", green_o, 4'b0001);
        cyc(4'b1010, 0, 1, 0);
        repeat (10) cyc(0, 0, 1, 0);
        chk("svc_p1", green_o, 4'b0010);
        repeat (11) cyc(0, 0, 1, 0);
        chk("svc_p3", green_o, 4'b1000);
        repeat (11) cyc(0, 0, 1, 0);
        chk("recall_p0", green_o, 4'b0001);
        cyc(4'b0010, 0, 1, 0);
        repeat (5) cyc(0, 0, 1, 0);
        chk("yel_pre_fl", yellow_o, 4'b0001);
        cyc(0, 1, 1, 0);
        chk("flash_on", flash_o, 1);
        chk("flash_r0", red_o, 4'h0);
        cyc(4'b1000, 1, 1, 0);
        chk("flash_r1", red_o, 4'hf);
        cyc(0, 1, 1, 0);
        chk("flash_r2", red_o, 4'h0);
        cyc(0, 1, 1, 0);
        chk("flash_r3", red_o, 4'hf);
        chk("flash_pend", pending_o, 4'b1010);
        cyc(0, 0, 1, 0);
        chk("flash_off", flash_o, 0);
        chk("exit_red", red_o, 4'hf);
        repeat (2) cyc(0, 0, 1, 0);
        chk("exit_p0", green_o, 4'b0001);
        for (int i = 0; i < 60 && green_o !== 4'b1000; i++) cyc(0, 0, 1, 0);
        chk("reach_p3", green_o, 4'b1000);
        repeat (2) cyc(0, 0, 1, 0);
        repeat (20) cyc(4'b0001, 0, 0, 0);
        chk("frz_green", green_o, 4'b1000);
        chk("frz_cnt", dut.count, 8'd2);
        chk("frz_pend", pending_o, 4'b0001);
        cyc(0, 0, 0, 1);
        chk("mid_rst_red", red_o, 4'hf);
        chk("mid_rst_pend", pending_o, 0);
        repeat (2) cyc(0, 0, 1, 0);
        chk("post_rst_p0", green_o, 4'b0001);
        #1;
        chk("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
